// File: rtl/video_stream_tx.sv
// Raster-timed pixel stream transmitter: emits vsync/hsync/valid_out plus
// r/g/b for one IMG_WIDTH x IMG_HEIGHT frame per period. Pixels come from an
// upstream ready/valid source or from an internal 8-bar colour pattern.
module video_stream_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int H_BLANK    = 16,
  parameter int H_SYNC     = 4,
  parameter int V_BLANK    = 4,
  parameter int V_SYNC     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  pattern_en,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_r,
  input  logic [DATA_WIDTH-1:0] pix_g,
  input  logic [DATA_WIDTH-1:0] pix_b,
  output logic                  pix_ready,
  output logic                  vsync,
  output logic                  hsync,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] r_out,
  output logic [DATA_WIDTH-1:0] g_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  underflow
);

  localparam int H_TOT = H_BLANK + IMG_WIDTH;
  localparam int V_TOT = V_BLANK + IMG_HEIGHT;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int BAR_W = IMG_WIDTH / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_MAX    = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_SYNC_C = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT    = HW'(H_BLANK);
  localparam logic [VW-1:0] V_MAX    = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_SYNC_C = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT    = VW'(V_BLANK);
  localparam logic [BW-1:0] BAR_MAX  = BW'(BAR_W - 1);
  localparam logic [DATA_WIDTH-1:0] C_ON = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         h_cnt_q, h_cnt_d;
  logic [VW-1:0]         v_cnt_q, v_cnt_d;
  logic                  pat_q, pat_d;
  logic [2:0]            bar_q, bar_d;
  logic [BW-1:0]         bar_px_q, bar_px_d;
  logic                  vsync_q, vsync_d;
  logic                  hsync_q, hsync_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                  frame_done_q, frame_done_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  underflow_q, underflow_d;

  logic run, hs, vs, act, h_last, last;

  // Slot decode for the current counter cycle.
  always_comb begin
    run    = (state_q == RUN);
    hs     = run && (h_cnt_q < H_SYNC_C);
    vs     = run && (v_cnt_q < V_SYNC_C);
    act    = run && (h_cnt_q >= H_ACT) && (v_cnt_q >= V_ACT);
    h_last = (h_cnt_q == H_MAX);
    last   = run && h_last && (v_cnt_q == V_MAX);
  end

  // Handshake: an upstream pixel transfers in a cycle where pix_valid and
  // pix_ready are both 1. pix_ready marks an active slot in upstream mode and
  // never waits on pix_valid; a missing pixel is replaced by black, not stalled.
  assign pix_ready = act && !pat_q;

  // FSM next state, raster counters, pattern latch and bar position.
  always_comb begin
    state_d  = state_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    pat_d    = pat_q;
    bar_d    = bar_q;
    bar_px_d = bar_px_q;
    case (state_q)
      IDLE: begin
        h_cnt_d  = '0;
        v_cnt_d  = '0;
        bar_d    = '0;
        bar_px_d = '0;
        if (enable) begin
          state_d = RUN;
          pat_d   = pattern_en;
        end
      end
      RUN: begin
        if (h_last) begin
          h_cnt_d  = '0;
          bar_d    = '0;
          bar_px_d = '0;
          if (v_cnt_q == V_MAX) begin
            v_cnt_d = '0;
            // Frame boundary: either start the next frame or stop cleanly.
            if (enable) pat_d = pattern_en;
            else        state_d = IDLE;
          end else begin
            v_cnt_d = v_cnt_q + 1'b1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
          if (act) begin
            if (bar_px_q == BAR_MAX) begin
              bar_px_d = '0;
              bar_d    = bar_q + 3'd1;
            end else begin
              bar_px_d = bar_px_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: everything is registered one cycle after its slot.
  always_comb begin
    vsync_d      = vs;
    hsync_d      = hs;
    valid_d      = act;
    r_d          = '0;
    g_d          = '0;
    b_d          = '0;
    frame_done_d = last;
    frame_cnt_d  = frame_cnt_q + (last ? 16'd1 : 16'd0);
    underflow_d  = underflow_q | (act && !pat_q && !pix_valid);
    if (act) begin
      if (pat_q) begin
        // Bars 0..7: white, yellow, cyan, green, magenta, red, blue, black.
        r_d = bar_q[1] ? '0 : C_ON;
        g_d = bar_q[2] ? '0 : C_ON;
        b_d = bar_q[0] ? '0 : C_ON;
      end else if (pix_valid) begin
        r_d = pix_r;
        g_d = pix_g;
        b_d = pix_b;
      end
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      pat_q        <= 1'b0;
      bar_q        <= '0;
      bar_px_q     <= '0;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      valid_q      <= 1'b0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      pat_q        <= pat_d;
      bar_q        <= bar_d;
      bar_px_q     <= bar_px_d;
      vsync_q      <= vsync_d;
      hsync_q      <= hsync_d;
      valid_q      <= valid_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      underflow_q  <= underflow_d;
    end
  end

  assign vsync      = vsync_q;
  assign hsync      = hsync_q;
  assign valid_out  = valid_q;
  assign r_out      = r_q;
  assign g_out      = g_q;
  assign b_out      = b_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_video_stream_tx.sv
// Bench for video_stream_tx on a reduced raster: 16x4 active, H_BLANK=4,
// H_SYNC=2, V_BLANK=2, V_SYNC=1 -> line 20 cycles, frame 120 cycles.
// Slot k is the counter cycle after posedge k of a run; its registered
// outputs are sampled at negedge k+1, pix_ready at negedge k.
module tb_video_stream_tx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, enable, pattern_en, pix_valid;
  logic [DW-1:0] pix_r, pix_g, pix_b;
  logic          pix_ready, vsync, hsync, valid_out, frame_done, underflow;
  logic [DW-1:0] r_out, g_out, b_out;
  logic [15:0]   frame_cnt;

  int cur;
  int drop_slot;
  int n_chk = 0;
  int n_err = 0;
  int cnt_vld, cnt_hs, cnt_vs, cnt_fd;

  typedef struct {
    int          slot;
    logic        rdy;
    logic        vs, hs, vld;
    logic [7:0]  r, g, b;
    logic        fd;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[11];
  logic [23:0] bars[8];

  video_stream_tx #(
    .DATA_WIDTH(8), .IMG_WIDTH(16), .IMG_HEIGHT(4),
    .H_BLANK(4), .H_SYNC(2), .V_BLANK(2), .V_SYNC(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_en(pattern_en),
    .pix_valid(pix_valid), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_ready(pix_ready), .vsync(vsync), .hsync(hsync), .valid_out(valid_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .underflow(underflow)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (sample %0d)", name, act, exp, cur);
    end
  endtask

  task automatic check_out(input string tag, input logic e_vs, input logic e_hs,
                           input logic e_vld, input logic [7:0] e_r, input logic [7:0] e_g,
                           input logic [7:0] e_b, input logic e_fd, input logic [15:0] e_fc);
    chk({tag, ".vsync"}, 32'(vsync), 32'(e_vs));
    chk({tag, ".hsync"}, 32'(hsync), 32'(e_hs));
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(e_vld));
    chk({tag, ".rgb"}, {8'h00, r_out, g_out, b_out}, {8'h00, e_r, e_g, e_b});
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(e_fd));
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(e_fc));
  endtask

  // Driver: one clock; upstream pixel for slot cur is r=cur, g=cur+1, b=cur+2.
  task automatic tick();
    @(posedge clk);
    cur++;
    #1;
    pix_valid = (cur != drop_slot);
    pix_r     = 8'(cur);
    pix_g     = 8'(cur + 1);
    pix_b     = 8'(cur + 2);
    @(negedge clk);
  endtask

  task automatic tick_to(input int target);
    while (cur < target) tick();
  endtask

  task automatic accumulate();
    if (valid_out)  cnt_vld++;
    if (hsync)      cnt_hs++;
    if (vsync)      cnt_vs++;
    if (frame_done) cnt_fd++;
  endtask

  initial begin
    // Upstream-mode checkpoints for frame 1 plus the first slot of frame 2.
    vecs[0]  = '{0,   1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0};
    vecs[1]  = '{1,   1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0};
    vecs[2]  = '{2,   1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0};
    vecs[3]  = '{20,  1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0};
    vecs[4]  = '{43,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0};
    vecs[5]  = '{44,  1'b1, 1'b0, 1'b0, 1'b1, 8'h2C, 8'h2D, 8'h2E, 1'b0, 16'd0};
    vecs[6]  = '{59,  1'b1, 1'b0, 1'b0, 1'b1, 8'h3B, 8'h3C, 8'h3D, 1'b0, 16'd0};
    vecs[7]  = '{60,  1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0};
    vecs[8]  = '{118, 1'b1, 1'b0, 1'b0, 1'b1, 8'h76, 8'h77, 8'h78, 1'b0, 16'd0};
    vecs[9]  = '{119, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 8'h78, 8'h79, 1'b1, 16'd1};
    vecs[10] = '{120, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd1};
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Reset
    rst = 1'b1; enable = 1'b0; pattern_en = 1'b0; pix_valid = 1'b0;
    pix_r = '0; pix_g = '0; pix_b = '0;
    cur = -100; drop_slot = -1;
    repeat (3) @(negedge clk);
    check_out("reset", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0);
    chk("reset.pix_ready", 32'(pix_ready), 32'd0);
    chk("reset.underflow", 32'(underflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Frame 1, upstream mode, table-driven checkpoints
    enable = 1'b1;
    cur = -1;
    for (int i = 0; i < 11; i++) begin
      tick_to(vecs[i].slot);
      chk($sformatf("v%0d.pix_ready", vecs[i].slot), 32'(pix_ready), 32'(vecs[i].rdy));
      tick();
      check_out($sformatf("v%0d", vecs[i].slot), vecs[i].vs, vecs[i].hs, vecs[i].vld,
                vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].fd, vecs[i].fc);
    end

    // Frame 2: one missing pixel, enable dropped mid-frame, whole-frame counts
    drop_slot = 185;
    cnt_vld = 0; cnt_hs = 0; cnt_vs = 0; cnt_fd = 0;
    accumulate();
    while (cur < 240) begin
      tick();
      accumulate();
      if (cur == 185) chk("uf.before", 32'(underflow), 32'd0);
      if (cur == 186) begin
        check_out("uf.pixel", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 16'd1);
        chk("uf.set", 32'(underflow), 32'd1);
      end
      if (cur == 187)
        check_out("uf.next", 1'b0, 1'b0, 1'b1, 8'hBA, 8'hBB, 8'hBC, 1'b0, 16'd1);
      if (cur == 200) enable = 1'b0;
    end
    check_out("f2.last", 1'b0, 1'b0, 1'b1, 8'hEF, 8'hF0, 8'hF1, 1'b1, 16'd2);
    chk("f2.valid_count", 32'(cnt_vld), 32'd64);
    chk("f2.hsync_count", 32'(cnt_hs), 32'd12);
    chk("f2.vsync_count", 32'(cnt_vs), 32'd20);
    chk("f2.frame_done_count", 32'(cnt_fd), 32'd1);

    // Back in IDLE after the completed frame
    drop_slot = -1;
    tick();
    check_out("idle", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd2);
    chk("idle.pix_ready", 32'(pix_ready), 32'd0);
    chk("idle.underflow", 32'(underflow), 32'd1);
    repeat (5) tick();
    check_out("idle.hold", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd2);

    // Restart in pattern mode
    pattern_en = 1'b1;
    enable = 1'b1;
    cur = -1;
    tick();
    tick();
    check_out("restart.s0", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd2);
    tick();
    chk("restart.s1.hsync", 32'(hsync), 32'd1);
    tick();
    chk("restart.s2.hsync", 32'(hsync), 32'd0);
    chk("restart.s2.vsync", 32'(vsync), 32'd1);
    for (int p = 0; p < 16; p++) begin
      tick_to(44 + p);
      chk($sformatf("bar.px%0d.pix_ready", p), 32'(pix_ready), 32'd0);
      tick();
      chk($sformatf("bar.px%0d.valid_out", p), 32'(valid_out), 32'd1);
      chk($sformatf("bar.px%0d.rgb", p), {8'h00, r_out, g_out, b_out}, {8'h00, bars[p / 2]});
    end

    // pattern_en change mid-frame is ignored until the frame wrap
    tick_to(70);
    pattern_en = 1'b0;
    tick_to(84);
    chk("latch.mid.pix_ready", 32'(pix_ready), 32'd0);
    tick();
    check_out("latch.mid", 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 16'd2);
    tick_to(120);
    chk("pat.frame_done", 32'(frame_done), 32'd1);
    chk("pat.frame_cnt", 32'(frame_cnt), 32'd3);
    tick_to(164);
    chk("latch.wrap.pix_ready", 32'(pix_ready), 32'd1);
    tick();
    check_out("latch.wrap", 1'b0, 1'b0, 1'b1, 8'hA4, 8'hA5, 8'hA6, 1'b0, 16'd3);

    // Asynchronous reset mid-line, checked before any clock edge
    tick_to(170);
    chk("prerst.valid_out", 32'(valid_out), 32'd1);
    chk("prerst.underflow", 32'(underflow), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_out("arst", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0);
    chk("arst.pix_ready", 32'(pix_ready), 32'd0);
    chk("arst.underflow", 32'(underflow), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Restart after reset begins at h=0,v=0
    cur = -1;
    tick();
    tick();
    check_out("post_rst.s0", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0);
    tick_to(44);
    chk("post_rst.pix_ready", 32'(pix_ready), 32'd1);
    tick();
    check_out("post_rst.first_px", 1'b0, 1'b0, 1'b1, 8'h2C, 8'h2D, 8'h2E, 1'b0, 16'd0);
    chk("post_rst.underflow", 32'(underflow), 32'd0);

    // Report
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/video_stream_tx.md
Name: video_stream_tx

Overview:
- Transmit end of the pixel stream interface consumed by the dehaze pipeline (vsync/hsync/valid_in/r/g/b).
- Generates raster timing and emits a frame of IMG_WIDTH x IMG_HEIGHT pixels per period.
- Pixel data comes from an upstream ready/valid source, or from an internal 8-bar colour pattern.
- Used as a frame player in benches and as the sensor-side driver on hardware.

Parameters:
DATA_WIDTH, 8, bits per colour channel
IMG_WIDTH, 320, active pixels per line; must be a multiple of 8
IMG_HEIGHT, 240, active lines per frame
H_BLANK, 16, blanking cycles per line, placed before the active pixels
H_SYNC, 4, hsync high cycles at the start of each line; 1 <= H_SYNC <= H_BLANK
V_BLANK, 4, blanking lines per frame, placed before the active lines
V_SYNC, 1, vsync high lines at the start of each frame; 1 <= V_SYNC <= V_BLANK

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
enable  in  1  run request; sampled only at frame boundaries
pattern_en  in  1  1 = colour bars, 0 = upstream pixels; latched at frame start
pix_valid  in  1  upstream pixel available
pix_r  in  DATA_WIDTH  upstream red
pix_g  in  DATA_WIDTH  upstream green
pix_b  in  DATA_WIDTH  upstream blue
pix_ready  out  1  upstream pixel accepted this cycle when pix_valid=1
vsync  out  1  vertical sync
hsync  out  1  horizontal sync
valid_out  out  1  active pixel on r/g/b_out
r_out  out  DATA_WIDTH  red
g_out  out  DATA_WIDTH  green
b_out  out  DATA_WIDTH  blue
frame_done  out  1  one-cycle pulse on the last cycle of each frame
frame_cnt  out  16  completed frames; wraps 0xFFFF -> 0
underflow  out  1  sticky: an active slot had no upstream pixel

Behaviour:
- Reset (async, rst=1): state IDLE, counters 0, pattern latch 0. All outputs 0.
- Counters:
  - h_cnt runs 0..H_BLANK+IMG_WIDTH-1.
  - v_cnt runs 0..V_BLANK+IMG_HEIGHT-1 and increments when h_cnt wraps.
- Line length L = H_BLANK+IMG_WIDTH cycles. Frame length F = L*(V_BLANK+IMG_HEIGHT) cycles.
- FSM:
  - IDLE: counters held at 0, all outputs 0 except frame_cnt/underflow. If enable=1, go to RUN; the next cycle is h=0,v=0.
  - RUN: counters advance every cycle. At the last frame cycle (h and v at max):
    - frame_done is asserted and frame_cnt increments, both registered so they appear in the same output cycle as that last frame position.
    - enable=1: continue with h=0,v=0. enable=0: go to IDLE.
  - Deasserting enable mid-frame never truncates a frame.
- Slot decode, per counter cycle t:
  - hs = RUN && h_cnt<H_SYNC.
  - vs = RUN && v_cnt<V_SYNC.
  - act = RUN && h_cnt>=H_BLANK && v_cnt>=V_BLANK.
- Outputs are registered, one cycle after their slot: vsync=vs, hsync=hs, valid_out=act.
- hsync pulses on every line, including vertical blanking lines.
- Upstream mode (pattern latch 0):
  - pix_ready = act, combinational from the counters in cycle t.
  - If pix_valid is also 1, pix_r/g/b is registered to r/g/b_out at t+1.
  - If act and pix_valid=0: output 0/0/0 with valid_out still 1, and set underflow. Timing never stalls.
- Pattern mode (pattern latch 1):
  - pix_ready = 0.
  - Bar index increments every IMG_WIDTH/8 active pixels and resets at each line start.
  - Bars 0..7 in order: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is all-ones (max = 2^DATA_WIDTH-1) or 0: R on bars 0,1,4,5; G on bars 0-3; B on bars 0,2,4,6.
- Outside active slots r/g/b_out = 0.
- pattern_en is latched at the IDLE->RUN transition and at each frame wrap. Mid-frame changes are ignored.
- underflow clears only on reset.
- Reset mid-frame: immediate return to the reset state. The next frame starts from h=0,v=0 after enable.

Test Plan:
- Defaults, enable=1, pattern_en=0, pix_valid=1 with an incrementing value:
  - exactly 76800 valid_out cycles per frame;
  - frame period 81984 cycles;
  - first valid_out 1 cycle after the h=16,v=4 slot.
- hsync/vsync widths:
  - hsync high 4 cycles every 336 cycles;
  - vsync high 336 cycles per frame;
  - vsync rises together with hsync.
- pattern_en=1, defaults:
  - line shows 40 px of (255,255,255), then (255,255,0), ..., last 40 px (0,0,0);
  - pix_ready stays 0.
- pix_valid=0 for one active slot:
  - that pixel is 0/0/0 with valid_out=1;
  - underflow goes 1 and stays 1;
  - remaining timing unchanged.
- Drop enable mid-frame 2:
  - frame 2 completes with frame_done pulse, frame_cnt=2, then IDLE and outputs 0;
  - re-raising enable restarts at h=0,v=0.
- Async rst mid-line:
  - all outputs 0 immediately, without a clock edge;
  - frame_cnt=0, underflow=0.
